lsu: RTL and testbench

Load/store unit for the RV32I core: sits directly downstream of the ALU and consumes its `result` as the effective address for loads and stores. Drives a word-addressed data-memory port with a req/ack handshake. Performs byte-lane steering, byte enables and load sign/zero extension. Holds `busy` to stall the core while an access is outstanding.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 59 +++++
 rtl/lsu.sv | 137 +++++++++++++
 tb/tb_lsu.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
// Holds the FSM state encoding, the funct3 size codes and the fault rule.
package lsu_pkg;

  localparam int REG_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned sizes exist only for loads; stores with BU/HU are illegal.
  function automatic logic is_fault(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                    input logic we);
    logic f;
    case (funct3)
      F3_B:    f = 1'b0;
      F3_H:    f = addr_lo[0];
      F3_W:    f = (addr_lo != 2'b00);
      F3_BU:   f = we;
      F3_HU:   f = we | addr_lo[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated store data,
// plus byte/half extraction and sign/zero extension of load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]           i_funct3,
  input  logic [1:0]           i_addr_lo,
  input  logic [REG_WIDTH-1:0] i_wdata,
  input  logic [REG_WIDTH-1:0] i_rdata,
  output logic [3:0]           o_be,
  output logic [REG_WIDTH-1:0] o_wdata,
  output logic [REG_WIDTH-1:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: enables and lane replication.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Load side: lane select then extension.
  always_comb begin
    w_byte  = 8'h00;
    w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_rdata = i_rdata;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'h000000, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'h0000, w_half};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: accepts one access at a time, drives a req/ack
// word-addressed memory port and returns extended load data.
module lsu
  import lsu_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset_b,
  input  logic                 i_start,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [2:0]           i_funct3,
  input  logic [REG_WIDTH-1:0] i_addr,
  input  logic [REG_WIDTH-1:0] i_wdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_fault,
  output logic [REG_WIDTH-1:0] o_rdata,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  output logic [REG_WIDTH-1:0] o_dmem_addr,
  output logic [3:0]           o_dmem_be,
  output logic [REG_WIDTH-1:0] o_dmem_wdata,
  input  logic                 i_dmem_ack,
  input  logic [REG_WIDTH-1:0] i_dmem_rdata
);

  lsu_state_e           r_state;
  lsu_state_e           w_next;
  logic                 w_accept;
  logic                 w_fault;
  logic [2:0]           r_funct3;
  logic [1:0]           r_addr_lo;
  logic                 r_we;
  logic [2:0]           w_f3;
  logic [1:0]           w_lo;
  logic [3:0]           w_be;
  logic [REG_WIDTH-1:0] w_wdata_rep;
  logic [REG_WIDTH-1:0] w_rdata_ext;

  logic                 r_busy, r_done, r_fault, r_dmem_req, r_dmem_we;
  logic [3:0]           r_dmem_be;
  logic [REG_WIDTH-1:0] r_rdata, r_dmem_addr, r_dmem_wdata;

  // The aligner sees live inputs while idle and the latched access otherwise.
  assign w_f3 = (r_state == S_IDLE) ? i_funct3 : r_funct3;
  assign w_lo = (r_state == S_IDLE) ? i_addr[1:0] : r_addr_lo;

  lsu_align u_align (
    .i_funct3  (w_f3),
    .i_addr_lo (w_lo),
    .i_wdata   (i_wdata),
    .i_rdata   (i_dmem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_rdata_ext)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_b) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic and accept decode.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_fault  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && (i_mem_read || i_mem_write)) begin
          w_accept = 1'b1;
          w_fault  = is_fault(i_funct3, i_addr[1:0], i_mem_write);
          w_next   = w_fault ? S_ERR : S_REQ;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ: begin
        if (i_dmem_ack) w_next = S_RESP;
        else            w_next = S_REQ;
      end
      S_RESP:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered outputs and latched access fields.
  always_ff @(posedge i_clk) begin
    if (!i_reset_b) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_rdata      <= 32'h0000_0000;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'h0000_0000;
      r_dmem_be    <= 4'b0000;
      r_dmem_wdata <= 32'h0000_0000;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_we         <= 1'b0;
    end else begin
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_RESP) || (w_next == S_ERR);
      r_fault <= (w_next == S_ERR);
      if (w_accept) begin
        r_funct3  <= i_funct3;
        r_addr_lo <= i_addr[1:0];
        r_we      <= i_mem_write;
        if (!w_fault) begin
          r_dmem_req   <= 1'b1;
          r_dmem_we    <= i_mem_write;
          r_dmem_addr  <= {i_addr[31:2], 2'b00};
          r_dmem_be    <= w_be;
          r_dmem_wdata <= w_wdata_rep;
        end
      end
      if (r_state == S_REQ && i_dmem_ack) begin
        r_dmem_req <= 1'b0;
        if (!r_we) r_rdata <= w_rdata_ext;
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_fault      = r_fault;
  assign o_rdata      = r_rdata;
  assign o_dmem_req   = r_dmem_req;
  assign o_dmem_we    = r_dmem_we;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_be    = r_dmem_be;
  assign o_dmem_wdata = r_dmem_wdata;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table with a completion scoreboard,
// plus hand-written reset-mid-access and held-start sequences.
module tb_lsu;

  logic        i_clk = 1'b0;
  logic        i_reset_b, i_start, i_mem_read, i_mem_write, i_dmem_ack;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata, i_dmem_rdata;
  logic        o_busy, o_done, o_fault, o_dmem_req, o_dmem_we;
  logic [31:0] o_rdata, o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;

  lsu dut (
    .i_clk(i_clk), .i_reset_b(i_reset_b), .i_start(i_start), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_fault(o_fault), .o_rdata(o_rdata),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack),
    .i_dmem_rdata(i_dmem_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]  f3;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          d;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mdl_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_access(input vec_t v);
    exp_t e;
    exp_t got;
    bit   seen;
    int   c;
    e.fault = v.fault;
    if (!v.fault && !v.we) mdl_rdata = v.erd;
    e.rdata = mdl_rdata;
    e.lat   = v.fault ? 1 : v.d + 2;
    sb.push_back(e);
    i_start = 1'b1; i_mem_read = !v.we; i_mem_write = v.we;
    i_funct3 = v.f3; i_addr = v.addr; i_wdata = v.wdata; i_dmem_rdata = v.mrd;
    seen = 1'b0;
    c = 0;
    while (!seen && c < 20) begin
      tick();
      c++;
      i_start = 1'b0;
      if (c == 1) begin
        chk("busy_first", {31'b0, o_busy}, 32'd1);
        chk("req_first", {31'b0, o_dmem_req}, {31'b0, !v.fault});
        if (!v.fault) begin
          chk("dmem_we", {31'b0, o_dmem_we}, {31'b0, v.we});
          chk("dmem_addr", o_dmem_addr, {v.addr[31:2], 2'b00});
          chk("dmem_be", {28'b0, o_dmem_be}, {28'b0, v.be});
          if (v.we) chk("dmem_wdata", o_dmem_wdata, v.ewd);
        end
      end
      if (v.fault) chk("req_on_fault", {31'b0, o_dmem_req}, 32'd0);
      i_dmem_ack = !v.fault && (c == v.d + 1);
      if (o_done) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          got = sb.pop_front();
          chk("latency", c, got.lat);
          chk("fault", {31'b0, o_fault}, {31'b0, got.fault});
          chk("rdata", o_rdata, got.rdata);
          chk("req_at_done", {31'b0, o_dmem_req}, 32'd0);
        end
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    i_dmem_ack = 1'b0;
    tick();
    chk("busy_after", {31'b0, o_busy}, 32'd0);
    chk("done_after", {31'b0, o_done}, 32'd0);
  endtask

  task automatic add(input logic [2:0] f3, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] mrd, input int d,
                     input logic flt, input logic [3:0] be, input logic [31:0] ewd,
                     input logic [31:0] erd);
    vec_t v;
    v.f3 = f3; v.we = we; v.addr = addr; v.wdata = wd; v.mrd = mrd; v.d = d;
    v.fault = flt; v.be = be; v.ewd = ewd; v.erd = erd;
    vecs.push_back(v);
  endtask

  initial begin
    i_reset_b = 1'b0; i_start = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_funct3 = 3'b000; i_addr = 32'h0; i_wdata = 32'h0; i_dmem_ack = 1'b0;
    i_dmem_rdata = 32'h0;

    //     f3      we    addr          wdata         mem rdata     d  flt   be       exp wdata     exp rdata
    add(3'b010, 1'b0, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 2, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF);
    add(3'b000, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_FF00, 1, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80);
    add(3'b100, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_FF00, 0, 1'b0, 4'b1000, 32'h0,        32'h0000_0080);
    add(3'b001, 1'b1, 32'h0000_0102, 32'h1234_ABCD, 32'h0,        0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
    add(3'b010, 1'b0, 32'h0000_1001, 32'h0,        32'h0,         0, 1'b1, 4'b0000, 32'h0,        32'h0);
    add(3'b101, 1'b1, 32'h0000_0102, 32'h1234_ABCD, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
    add(3'b001, 1'b0, 32'h0000_2002, 32'h0,        32'h8001_7FFF, 1, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001);
    add(3'b101, 1'b0, 32'h0000_2000, 32'h0,        32'h8001_7FFF, 0, 1'b0, 4'b0011, 32'h0,        32'h0000_7FFF);
    add(3'b000, 1'b1, 32'h0000_0301, 32'h0000_00A5, 32'h0,        3, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    add(3'b010, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0);
    add(3'b011, 1'b0, 32'h0000_0400, 32'h0,        32'h0,         0, 1'b1, 4'b0000, 32'h0,        32'h0);
    add(3'b000, 1'b0, 32'h0000_0000, 32'h0,        32'h1234_567F, 0, 1'b0, 4'b0001, 32'h0,        32'h0000_007F);
    add(3'b001, 1'b0, 32'h0000_1003, 32'h0,        32'h0,         0, 1'b1, 4'b0000, 32'h0,        32'h0);
    add(3'b100, 1'b1, 32'h0000_0000, 32'h0,        32'h0,         0, 1'b1, 4'b0000, 32'h0,        32'h0);

    tick(); tick();
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_done", {31'b0, o_done}, 32'd0);
    chk("rst_req", {31'b0, o_dmem_req}, 32'd0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_be", {28'b0, o_dmem_be}, 32'd0);
    i_reset_b = 1'b1;
    tick();

    // Start with neither read nor write is ignored.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("nop_start_busy", {31'b0, o_busy}, 32'd0);

    foreach (vecs[i]) run_access(vecs[i]);

    // Reset while waiting for ack, then a late ack.
    i_start = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_funct3 = 3'b010;
    i_addr = 32'h0000_0500; i_dmem_rdata = 32'h5555_AAAA;
    tick();
    i_start = 1'b0;
    chk("mid_req", {31'b0, o_dmem_req}, 32'd1);
    i_reset_b = 1'b0;
    tick();
    i_reset_b = 1'b1; i_dmem_ack = 1'b1;
    chk("mid_rst_req", {31'b0, o_dmem_req}, 32'd0);
    chk("mid_rst_busy", {31'b0, o_busy}, 32'd0);
    chk("mid_rst_done", {31'b0, o_done}, 32'd0);
    chk("mid_rst_rdata", o_rdata, 32'h0);
    chk("mid_rst_addr", o_dmem_addr, 32'h0);
    chk("mid_rst_we", {31'b0, o_dmem_we}, 32'd0);
    mdl_rdata = 32'h0;
    tick();
    i_dmem_ack = 1'b0;
    chk("late_ack_done", {31'b0, o_done}, 32'd0);
    chk("late_ack_busy", {31'b0, o_busy}, 32'd0);
    run_access(vecs[0]);

    // Start held through an access; second request offered after done.
    i_start = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_funct3 = 3'b010;
    i_addr = 32'h0000_1000; i_dmem_rdata = 32'h1122_3344;
    tick();
    chk("held_req", {31'b0, o_dmem_req}, 32'd1);
    i_dmem_ack = 1'b1;
    tick();
    i_dmem_ack = 1'b0;
    chk("held_done", {31'b0, o_done}, 32'd1);
    chk("held_rdata", o_rdata, 32'h1122_3344);
    tick();
    chk("held_idle_busy", {31'b0, o_busy}, 32'd0);
    chk("held_no_reaccept", {31'b0, o_dmem_req}, 32'd0);
    chk("held_idle_done", {31'b0, o_done}, 32'd0);
    i_mem_read = 1'b0; i_mem_write = 1'b1; i_addr = 32'h0000_2000; i_wdata = 32'h5566_7788;
    tick();
    chk("second_req", {31'b0, o_dmem_req}, 32'd1);
    chk("second_we", {31'b0, o_dmem_we}, 32'd1);
    chk("second_addr", o_dmem_addr, 32'h0000_2000);
    chk("second_wdata", o_dmem_wdata, 32'h5566_7788);
    i_dmem_ack = 1'b1;
    tick();
    i_dmem_ack = 1'b0; i_start = 1'b0;
    chk("second_done", {31'b0, o_done}, 32'd1);
    chk("second_rdata_kept", o_rdata, 32'h1122_3344);
    tick();
    chk("second_after_busy", {31'b0, o_busy}, 32'd0);
    chk("second_after_req", {31'b0, o_dmem_req}, 32'd0);
    chk("second_after_done", {31'b0, o_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
